// File: rtl/fifo_sync_param_pkg.sv
// Shared sizing helpers for the parametrised synchronous FIFO.
// Pointer and count widths are derived from DEPTH here.
package fifo_sync_param_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int addr_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param.
// master drives requests; slave is the FIFO itself.
interface fifo_sync_param_if
    import fifo_sync_param_pkg::*;
#(
    parameter int BITNUMBER = 10,
    parameter int DEPTH     = 8
);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [BITNUMBER-1:0] data_in;
    logic                 write;
    logic                 read;
    logic [BITNUMBER-1:0] data_out;
    logic                 valid_out;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CNT_W-1:0]     count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output data_in, write, read,
        input  data_out, valid_out, full, empty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  data_in, write, read,
        output data_out, valid_out, full, empty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param_mem_2p.sv
// Unreset two-port storage: synchronous write, asynchronous read.
module fifo_mem_2p #(
    parameter int BITNUMBER = 10,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [BITNUMBER-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [BITNUMBER-1:0] rdata
);
    logic [BITNUMBER-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered read data and status flags.
// Define FIFO_ERR_FLAGS_EN to enable sticky overflow/underflow flags.
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int BITNUMBER = 10,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input logic               clk,
    input logic               reset,
    fifo_sync_param_if.slave  bus
);
    localparam int ADDR_W = addr_w(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    logic [ADDR_W-1:0]    wr_ptr;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]     cnt;
    logic [BITNUMBER-1:0] rdata;
    logic                 wr_acc;
    logic                 rd_acc;

    // Flags decode only the registered count.
    assign bus.full         = (cnt == CNT_W'(DEPTH));
    assign bus.empty        = (cnt == '0);
    assign bus.almost_full  = (cnt >= CNT_W'(DEPTH - AF_MARGIN));
    assign bus.almost_empty = (cnt <= CNT_W'(AE_MARGIN));
    assign bus.count        = cnt;

    assign rd_acc = bus.read & ~bus.empty;
    assign wr_acc = bus.write & (~bus.full | bus.read);

    fifo_mem_2p #(
        .BITNUMBER (BITNUMBER),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            cnt           <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
        end else begin
            bus.valid_out <= rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_acc) begin
                rd_ptr       <= rd_ptr + ADDR_W'(1);
                bus.data_out <= rdata;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (bus.write & bus.full & ~bus.read) bus.overflow <= 1'b1;
            if (bus.read & bus.empty) bus.underflow <= 1'b1;
        end
    end
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised bench for fifo_sync_param against a queue-based model.
// Error-flag expectations follow FIFO_ERR_FLAGS_EN.
module tb_fifo_sync_param;
    localparam int BW    = 10;
    localparam int DEPTH = 8;
    localparam int AFM   = 1;
    localparam int AEM   = 1;

    logic clk;
    logic reset;

    fifo_sync_param_if #(.BITNUMBER(BW), .DEPTH(DEPTH)) bus ();

    fifo_sync_param #(
        .BITNUMBER (BW),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AFM),
        .AE_MARGIN (AEM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [BW-1:0] q[$];
    logic [BW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, int'(bus.count), n);
        chk({tag, ".full"}, int'(bus.full), int'(n == DEPTH));
        chk({tag, ".empty"}, int'(bus.empty), int'(n == 0));
        chk({tag, ".afull"}, int'(bus.almost_full), int'(n >= DEPTH - AFM));
        chk({tag, ".aempty"}, int'(bus.almost_empty), int'(n <= AEM));
        chk({tag, ".valid"}, int'(bus.valid_out), int'(m_valid));
        chk({tag, ".dout"}, int'(bus.data_out), int'(m_dout));
        chk({tag, ".ovf"}, int'(bus.overflow), int'(m_ovf));
        chk({tag, ".unf"}, int'(bus.underflow), int'(m_unf));
    endtask

    task automatic model_reset();
        q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock with the given requests; model applies the FIFO rules.
    task automatic step(input string tag, input logic w, input logic r,
                        input logic [BW-1:0] d);
        int  n;
        bit  wa;
        bit  ra;
        bus.write   = w;
        bus.read    = r;
        bus.data_in = d;
        n  = q.size();
        ra = r && (n > 0);
        wa = w && ((n < DEPTH) || r);
        @(posedge clk);
        m_valid = ra;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
        if (ERR_EN && w && n == DEPTH && !r) m_ovf = 1'b1;
        if (ERR_EN && r && n == 0) m_unf = 1'b1;
        #1;
        chk_all(tag);
        bus.write = 1'b0;
        bus.read  = 1'b0;
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int pw;
        int pr;
        reset        = 1'b0;
        bus.write    = 1'b0;
        bus.read     = 1'b0;
        bus.data_in  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, BW'(i));
        for (int i = 1; i <= DEPTH; i++) step("drain", 1'b0, 1'b1, '0);
        step("drain_idle", 1'b0, 1'b0, '0);

        for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 1'b0, BW'(16 + i));
        for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++) step("wrap_w8", 1'b1, 1'b0, BW'(32 + i));
        for (int i = 0; i < 8; i++) step("wrap_r8", 1'b0, 1'b1, '0);

        for (int i = 0; i < DEPTH; i++) step("frw_fill", 1'b1, 1'b0, BW'(64 + i));
        step("full_rw", 1'b1, 1'b1, 10'h3FF);
        for (int i = 0; i < DEPTH; i++) step("frw_drain", 1'b0, 1'b1, '0);

        step("empty_rw", 1'b1, 1'b1, 10'h155);
        step("empty_rw_rd", 1'b0, 1'b1, '0);

        for (int i = 0; i < DEPTH; i++) step("err_fill", 1'b1, 1'b0, BW'(i));
        step("ovf", 1'b1, 1'b0, 10'h2AA);
        step("ovf_hold", 1'b0, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) step("err_drain", 1'b0, 1'b1, '0);
        step("unf", 1'b0, 1'b1, '0);
        step("unf_hold", 1'b0, 1'b0, '0);

        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, BW'($urandom));
        mid_reset("mid_rst");

        for (int blk = 0; blk < 15; blk++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                step("rand",
                     1'($urandom_range(0, 99) < pw),
                     1'($urandom_range(0, 99) < pr),
                     BW'($urandom));
            end
            if (blk == 7) mid_reset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
